trivium_ks_ctrl: RTL and testbench
==================================

# trivium_ks_ctrl

Sequencer for the `trivium_wrapper` keystream core. It latches a key/IV pair on a start pulse and resets the core. It then waits for initialization and pulls successive 64-bit keystream blocks through `next_data`. Blocks are presented to a consumer over a valid/ready handshake, and the controller stops after a programmed block count. It sits between the autotest/host logic and the `trivium_wrapper` instance.

## Interface
Parameters:
- `DATA_WIDTH`, 64: keystream block width; must match the wrapper.
- `KEY_W`, 80: key width.
- `IV_W`, 80: IV width.
- `CNT_W`, 32: block counter width.
- `RST_CYCLES`, 2: number of cycles `core_rst` is held high per load.
- `TIMEOUT_CYCLES`, 4096: watchdog limit while waiting on `core_end`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: load request; sampled only in IDLE, DONE or ERROR.
- `abort`, in, 1: return to IDLE from any state.
- `key_i`, in, KEY_W: key; latched when `start` is accepted.
- `iv_i`, in, IV_W: IV; latched when `start` is accepted.
- `n_blocks_i`, in, CNT_W: blocks to deliver; 0 means unbounded. Latched when `start` is accepted.
- `ks_data_o`, out, DATA_WIDTH: keystream block.
- `ks_valid_o`, out, 1: `ks_data_o` is valid.
- `ks_ready_i`, in, 1: consumer accepts the block.
- `busy_o`, out, 1: high outside IDLE, DONE and ERROR.
- `done_o`, out, 1: high in DONE.
- `err_o`, out, 1: high in ERROR (sticky).
- `blk_cnt_o`, out, CNT_W: number of blocks handed to the consumer.
- `core_rst`, out, 1: drives the wrapper `rst`.
- `core_key`, out, KEY_W: drives the wrapper `key`.
- `core_iv`, out, IV_W: drives the wrapper `iv`.
- `core_next`, out, 1: drives the wrapper `next_data`.
- `core_end`, in, 1: from the wrapper `end_block`.
- `core_block`, in, DATA_WIDTH: from the wrapper `block_o`.

## Operation
Wrapper contract:
- `core_end` high means `core_block` is valid and held.
- A one-cycle `core_next` pulse requests the next block; `core_end` drops, then rises again when the new block is ready.

States:
- IDLE: accepted `start` latches key, IV and count; clears the counter, error and output register; go to LOAD.
- LOAD: `core_rst`=1 for RST_CYCLES cycles; then go to WAIT_HI.
- WAIT_HI: wait for `core_end`=1. Capture when it is high and the output slot is free, or freed this cycle (`ks_valid_o & ks_ready_i`).
  - On capture: `ks_data_o`←`core_block`, `ks_valid_o`←1, produced count +1.
  - If the produced count now equals `n_blocks` (nonzero), go to DRAIN.
  - Otherwise pulse `core_next`=1 for one cycle and go to WAIT_LO.
  - If the slot stays full, hold in WAIT_HI; the block remains buffered in the wrapper, giving 2 blocks of effective buffering.
- WAIT_LO: wait for `core_end`=0, then go to WAIT_HI.
- DRAIN: wait for the last block to be accepted, then go to DONE.
- DONE: `done_o`=1; `start` re-enters LOAD with new operands.
- ERROR: `err_o`=1; leave on `start` (to LOAD) or `abort` (to IDLE).
- Watchdog: counts cycles spent in WAIT_HI with `core_end`=0, and all cycles in WAIT_LO. It clears on every state change. Reaching TIMEOUT_CYCLES forces ERROR, clears `ks_valid_o` and drops any pending block.
- `abort` (any state): go to IDLE, `ks_valid_o`←0, `core_rst`←1 for one cycle. `abort` takes priority over `start` and capture in the same cycle.
- `blk_cnt_o` increments on each `ks_valid_o & ks_ready_i`. It wraps modulo 2^CNT_W when unbounded.

## Timing
- Reset values: `ks_valid_o`=0, `ks_data_o`=0, `core_rst`=1, `core_next`=0, `busy_o`=0, `done_o`=0, `err_o`=0, `blk_cnt_o`=0, `core_key`=0, `core_iv`=0. State is IDLE.
- `start` accepted at edge E: `core_rst` is high for the RST_CYCLES cycles after E, and the operands are stable from E+1 onward.
- `core_end` high in cycle t with the slot free: `ks_valid_o` and `core_next` are both high in t+1. `core_next` is high for exactly one cycle.
- `ks_data_o` stays stable while `ks_valid_o`=1 and `ks_ready_i`=0.
- Back-to-back throughput is bounded by the core; the controller adds 1 cycle of capture latency.
- `core_next` is never asserted after the final counted block.
- All outputs are registered; no combinational path from `ks_ready_i` to any output.

## Structure
- `trivium_ctrl_pkg`: state enum (IDLE, LOAD, WAIT_HI, WAIT_LO, DRAIN, DONE, ERROR), default KEY_W/IV_W/DATA_WIDTH localparams.
- Sub-module `ks_watchdog` (clear/enable/expire counter, TIMEOUT_CYCLES parameter); everything else lives in one FSM module.

## Test plan
- Key 0, IV 0, `n_blocks`=4, `ks_ready_i`=1: 4 blocks equal to the model keystream; `core_next` pulses 3 times; `done_o`=1 with `blk_cnt_o`=4.
- `n_blocks`=3 with `ks_ready_i` low for 20 cycles after the first block: data held stable; second block stays buffered in the wrapper; no `core_next` until the slot frees; all 3 blocks correct and in order.
- `n_blocks`=0, ready toggling every cycle for 100 blocks: unbounded stream; `busy_o` stays 1; `blk_cnt_o`=100.
- Stub that never raises `core_end`, TIMEOUT_CYCLES=16: `err_o` rises 16 cycles into WAIT_HI; a later `start` recovers.
- `abort` during WAIT_LO with `ks_valid_o`=1: next cycle IDLE, `ks_valid_o`=0, `core_rst`=1 for one cycle.
- `rst` asserted mid-stream: all outputs take their reset values on the next edge.

Source files
------------

// File: rtl/trivium_ks_ctrl_pkg.sv
// Shared types and default widths for the Trivium keystream sequencer.
package trivium_ctrl_pkg;

    localparam int DEF_KEY_W      = 80;
    localparam int DEF_IV_W       = 80;
    localparam int DEF_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO,
        DRAIN,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/trivium_ks_ctrl_if.sv
// Keystream block stream from the sequencer to its consumer (valid/ready).
interface trivium_ks_ctrl_if #(
    parameter int DATA_WIDTH = 64
) ();

    logic [DATA_WIDTH-1:0] ks_data_o;
    logic                  ks_valid_o;
    logic                  ks_ready_i;

    modport master (output ks_data_o, output ks_valid_o, input ks_ready_i);
    modport slave  (input ks_data_o, input ks_valid_o, output ks_ready_i);

endinterface

// File: rtl/trivium_ks_ctrl_watchdog.sv
// Down-counting watchdog: reloads on clear, counts enabled cycles, flags the last one.
module ks_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Asserted during the TIMEOUT_CYCLES-th enabled cycle so the FSM leaves on that edge.
    assign expire = en && (cnt == CW'(1));

endmodule

// File: rtl/trivium_ks_ctrl.sv
// Sequencer that loads a trivium_wrapper and streams its keystream blocks to a consumer.
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD    | core held in reset for RST_CYCLES cycles
//   WAIT_HI | waiting for core_end, capture when the output slot is free
//   WAIT_LO | next_data issued, waiting for core_end to drop
//   DRAIN   | final block captured, waiting for the consumer to take it
//   DONE    | programmed block count delivered
//   ERROR   | watchdog expired while waiting on the core
module trivium_ks_ctrl
    import trivium_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int KEY_W          = DEF_KEY_W,
    parameter int IV_W           = DEF_IV_W,
    parameter int CNT_W          = 32,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_W-1:0]      key_i,
    input  logic [IV_W-1:0]       iv_i,
    input  logic [CNT_W-1:0]      n_blocks_i,
    trivium_ks_ctrl_if.master     ks,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      blk_cnt_o,
    output logic                  core_rst,
    output logic [KEY_W-1:0]      core_key,
    output logic [IV_W-1:0]       core_iv,
    output logic                  core_next,
    input  logic                  core_end,
    input  logic [DATA_WIDTH-1:0] core_block
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);

    state_t                state, state_nxt;
    logic [RC_W-1:0]       rst_cnt;
    logic [CNT_W-1:0]      n_q;
    logic [CNT_W-1:0]      prod_cnt;
    logic [CNT_W-1:0]      prod_inc;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  handshake;
    logic                  slot_free;
    logic                  start_ok;
    logic                  capture;
    logic                  last;
    logic                  wd_en;
    logic                  wd_expire;

    assign handshake = valid_q && ks.ks_ready_i;
    assign slot_free = !valid_q || ks.ks_ready_i;
    assign start_ok  = start && (state == IDLE || state == DONE || state == ERROR);
    assign prod_inc  = prod_cnt + CNT_W'(1);
    assign last      = (n_q != '0) && (prod_inc == n_q);
    assign capture   = (state == WAIT_HI) && core_end && slot_free && !abort;
    assign wd_en     = ((state == WAIT_HI) && !core_end) || (state == WAIT_LO);

    ks_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_nxt != state),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (wd_expire) begin
            state_nxt = ERROR;
        end else begin
            unique case (state)
                IDLE, DONE, ERROR: if (start) state_nxt = LOAD;
                LOAD:              if (rst_cnt == '0) state_nxt = WAIT_HI;
                WAIT_HI:           if (capture) state_nxt = last ? DRAIN : WAIT_LO;
                WAIT_LO:           if (!core_end) state_nxt = WAIT_HI;
                DRAIN:             if (handshake) state_nxt = DONE;
                default:           state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = !(state inside {IDLE, DONE, ERROR});
        done_o = (state == DONE);
        err_o  = (state == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_key  <= '0;
            core_iv   <= '0;
            n_q       <= '0;
            prod_cnt  <= '0;
            blk_cnt_o <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            core_rst  <= 1'b1;
            core_next <= 1'b0;
            rst_cnt   <= '0;
        end else begin
            // Core reset follows LOAD occupancy, plus a single pulse on abort.
            core_rst  <= abort || (state_nxt == LOAD);
            core_next <= capture && !last;
            if (start_ok && !abort) begin
                core_key  <= key_i;
                core_iv   <= iv_i;
                n_q       <= n_blocks_i;
                prod_cnt  <= '0;
                blk_cnt_o <= '0;
                data_q    <= '0;
                valid_q   <= 1'b0;
                rst_cnt   <= RC_W'(RST_CYCLES - 1);
            end else begin
                if (state == LOAD && rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
                if (handshake) blk_cnt_o <= blk_cnt_o + CNT_W'(1);
                if (abort || wd_expire) begin
                    valid_q <= 1'b0;
                end else if (capture) begin
                    data_q   <= core_block;
                    valid_q  <= 1'b1;
                    prod_cnt <= prod_inc;
                end else if (handshake) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign ks.ks_data_o  = data_q;
    assign ks.ks_valid_o = valid_q;

endmodule

// File: tb/tb_trivium_ks_ctrl.sv
// Bench for trivium_ks_ctrl: behavioural keystream core stub plus an index-based block model.
module tb_trivium_ks_ctrl;

    localparam int DW = 64;
    localparam int KW = 80;
    localparam int VW = 80;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [KW-1:0] key_i = '0;
    logic [VW-1:0] iv_i = '0;
    logic [CW-1:0] n_blocks_i = '0;
    logic          busy_o, done_o, err_o;
    logic [CW-1:0] blk_cnt_o;
    logic          core_rst, core_next, core_end;
    logic [KW-1:0] core_key;
    logic [VW-1:0] core_iv;
    logic [DW-1:0] core_block;

    trivium_ks_ctrl_if #(.DATA_WIDTH(DW)) ks_if ();

    trivium_ks_ctrl #(
        .DATA_WIDTH(DW), .KEY_W(KW), .IV_W(VW), .CNT_W(CW),
        .RST_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .key_i(key_i), .iv_i(iv_i), .n_blocks_i(n_blocks_i),
        .ks(ks_if.master),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .blk_cnt_o(blk_cnt_o),
        .core_rst(core_rst), .core_key(core_key), .core_iv(core_iv),
        .core_next(core_next), .core_end(core_end), .core_block(core_block)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Block i of a key/IV session; the stub core serves exactly this sequence.
    function automatic logic [63:0] ks_model(input logic [79:0] k, input logic [79:0] v, input int i);
        logic [63:0] m;
        m = 64'(i + 1) * 64'h9E37_79B9_7F4A_7C15;
        return k[63:0] ^ {v[47:0], k[79:64]} ^ {v[79:48], 32'(i)} ^ m;
    endfunction

    // Wrapper stub: reset restarts the sequence, next_data advances after a random delay.
    logic c_end = 1'b0;
    int   c_idx = 0;
    int   c_wait = 0;
    bit   dead = 1'b0;

    always @(posedge clk) begin
        if (core_rst) begin
            c_end  <= 1'b0;
            c_idx  <= 0;
            c_wait <= 3;
        end else if (dead) begin
            c_end <= 1'b0;
        end else if (c_end) begin
            if (core_next) begin
                c_end  <= 1'b0;
                c_idx  <= c_idx + 1;
                c_wait <= int'($urandom_range(0, 3));
            end
        end else if (c_wait > 0) begin
            c_wait <= c_wait - 1;
        end else begin
            c_end <= 1'b1;
        end
    end

    assign core_end   = c_end;
    assign core_block = c_end ? ks_model(core_key, core_iv, c_idx) : 64'hBAD0_BAD0_BAD0_BAD0;

    logic [KW-1:0] cur_key = '0;
    logic [VW-1:0] cur_iv = '0;
    int hs_total = 0, hs_base = 0;
    int next_total = 0, next_base = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0, prev_rst = 1'b1, prev_next = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ks_if.ks_valid_o && ks_if.ks_ready_i) begin
                chk("ks_data", ks_if.ks_data_o, ks_model(cur_key, cur_iv, hs_total - hs_base));
                chk("blk_cnt_hs", 64'(blk_cnt_o), 64'(hs_total - hs_base));
                hs_total++;
            end
            if (prev_valid && !prev_ready && !prev_abort && !prev_rst) begin
                chk("hold_valid", 64'(ks_if.ks_valid_o), 64'd1);
                chk("hold_data", ks_if.ks_data_o, prev_data);
            end
            if (core_next) begin
                chk("next_width", 64'(prev_next), 64'd0);
                chk("next_with_end", 64'(core_end), 64'd1);
                next_total++;
            end
        end
        prev_valid = ks_if.ks_valid_o;
        prev_ready = ks_if.ks_ready_i;
        prev_data  = ks_if.ks_data_o;
        prev_abort = abort;
        prev_rst   = rst;
        prev_next  = core_next;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input int mode);
        case (mode)
            0:       ks_if.ks_ready_i = 1'b1;
            1:       ks_if.ks_ready_i = 1'($urandom_range(0, 1));
            default: ks_if.ks_ready_i = ~ks_if.ks_ready_i;
        endcase
    endtask

    // Issues start; returns right after the second reset cycle (first WAIT_HI cycle).
    task automatic do_start(input logic [79:0] k, input logic [79:0] v, input int n);
        key_i      = k;
        iv_i       = v;
        n_blocks_i = CW'(n);
        cur_key    = k;
        cur_iv     = v;
        hs_base    = hs_total;
        next_base  = next_total;
        start      = 1'b1;
        tick();
        start = 1'b0;
        key_i = '0;
        iv_i  = '0;
        chk("load_rst1", 64'(core_rst), 64'd1);
        chk("load_key", core_key[63:0], k[63:0]);
        chk("load_err_clr", 64'(err_o), 64'd0);
        chk("load_busy", 64'(busy_o), 64'd1);
        tick();
        chk("load_rst2", 64'(core_rst), 64'd1);
        chk("load_iv", core_iv[63:0], v[63:0]);
        tick();
        chk("load_rst_end", 64'(core_rst), 64'd0);
    endtask

    task automatic wait_done(input int n, input int mode);
        int t;
        t = 0;
        while (!done_o && t < 3000) begin
            drive_ready(mode);
            tick();
            t++;
        end
        chk("done_reached", 64'(done_o), 64'd1);
        chk("blk_cnt_end", 64'(blk_cnt_o), 64'(n));
        chk("blocks_seen", 64'(hs_total - hs_base), 64'(n));
        chk("next_pulses", 64'(next_total - next_base), 64'(n - 1));
        chk("busy_end", 64'(busy_o), 64'd0);
        chk("valid_end", 64'(ks_if.ks_valid_o), 64'd0);
    endtask

    initial begin
        int t;
        int cnt;
        bit busy_dropped;
        ks_if.ks_ready_i = 1'b0;

        repeat (3) tick();
        chk("rst_valid", 64'(ks_if.ks_valid_o), 64'd0);
        chk("rst_data", ks_if.ks_data_o, 64'd0);
        chk("rst_core_rst", 64'(core_rst), 64'd1);
        chk("rst_next", 64'(core_next), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst = 1'b0;
        tick();
        tick();

        // Zero key/IV, four blocks, always ready
        do_start('0, '0, 4);
        wait_done(4, 0);

        // Three blocks with the consumer stalled after the first
        ks_if.ks_ready_i = 1'b0;
        do_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 3);
        t = 0;
        while (!ks_if.ks_valid_o && t < 200) begin tick(); t++; end
        chk("stall_first_valid", 64'(ks_if.ks_valid_o), 64'd1);
        repeat (20) tick();
        chk("stall_valid_held", 64'(ks_if.ks_valid_o), 64'd1);
        chk("stall_core_buffered", 64'(core_end), 64'd1);
        chk("stall_next_once", 64'(next_total - next_base), 64'd1);
        chk("stall_cnt", 64'(blk_cnt_o), 64'd0);
        wait_done(3, 0);

        // Randomized bounded runs
        for (int r = 0; r < 4; r++) begin
            int nb;
            nb = int'($urandom_range(1, 6));
            do_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, nb);
            wait_done(nb, 1);
        end

        // Unbounded stream, ready toggling, stop after 100 blocks
        ks_if.ks_ready_i = 1'b0;
        busy_dropped = 1'b0;
        do_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 0);
        t = 0;
        while ((hs_total - hs_base) < 100 && t < 3000) begin
            drive_ready(2);
            tick();
            if (!busy_o) busy_dropped = 1'b1;
            t++;
        end
        ks_if.ks_ready_i = 1'b0;
        chk("unb_blk_cnt", 64'(blk_cnt_o), 64'd100);
        chk("unb_busy_stayed", 64'(busy_dropped), 64'd0);
        chk("unb_no_done", 64'(done_o), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("unb_abort_busy", 64'(busy_o), 64'd0);
        chk("unb_abort_valid", 64'(ks_if.ks_valid_o), 64'd0);
        tick();

        // Abort while waiting for core_end to drop with a block pending
        do_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 0);
        t = 0;
        while (!core_next && t < 200) begin tick(); t++; end
        chk("abort_setup_next", 64'(core_next), 64'd1);
        chk("abort_setup_valid", 64'(ks_if.ks_valid_o), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 64'(ks_if.ks_valid_o), 64'd0);
        chk("abort_core_rst", 64'(core_rst), 64'd1);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_next", 64'(core_next), 64'd0);
        tick();
        chk("abort_core_rst_1cyc", 64'(core_rst), 64'd0);

        // Dead core: watchdog must fire after 16 cycles in WAIT_HI
        dead = 1'b1;
        ks_if.ks_ready_i = 1'b1;
        do_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 2);
        cnt = 0;
        while (!err_o && cnt < 100) begin cnt++; tick(); end
        chk("wd_cycles", 64'(cnt), 64'd16);
        chk("wd_err", 64'(err_o), 64'd1);
        chk("wd_busy", 64'(busy_o), 64'd0);
        chk("wd_valid", 64'(ks_if.ks_valid_o), 64'd0);
        repeat (3) tick();
        chk("wd_err_sticky", 64'(err_o), 64'd1);
        dead = 1'b0;
        do_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 2);
        wait_done(2, 0);

        // Synchronous reset in the middle of a stream
        do_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 0);
        repeat (30) begin drive_ready(1); tick(); end
        rst = 1'b1;
        tick();
        chk("mrst_valid", 64'(ks_if.ks_valid_o), 64'd0);
        chk("mrst_data", ks_if.ks_data_o, 64'd0);
        chk("mrst_core_rst", 64'(core_rst), 64'd1);
        chk("mrst_next", 64'(core_next), 64'd0);
        chk("mrst_busy", 64'(busy_o), 64'd0);
        chk("mrst_done", 64'(done_o), 64'd0);
        chk("mrst_err", 64'(err_o), 64'd0);
        chk("mrst_blk_cnt", 64'(blk_cnt_o), 64'd0);
        chk("mrst_key", core_key[63:0], 64'd0);
        chk("mrst_iv", core_iv[63:0], 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
